vga_pattern_scroller: RTL
=========================

# vga_pattern_scroller

Parametrised successor to the single-mode scrolling VGA test pattern. It sits between `hvsync_generator` and the TinyVGA PMOD output mapping. It consumes beam position and sync signals and produces registered, blanked RGB in one of four selectable patterns. Horizontal scroll speed and direction are programmable, and vertical scroll is optional. All state runs in the pixel clock domain; no logic is clocked by `vsync`.

## Interface
Parameters:
- `COORD_W`, default 10: beam coordinate and scroll offset width. Must satisfy `COORD_W >= COLOR_BITS + 6`.
- `COLOR_BITS`, default 2: bits per colour channel. Must be ≥ 1.
- `SPEED_W`, default 3: width of the scroll step input.

Ports:
- `clk`, in, 1: pixel clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `hsync_in`, `vsync_in`, in, 1 each: active-low syncs from the timing generator.
- `display_on`, in, 1: visible-area flag.
- `hpos`, `vpos`, in, `COORD_W` each: beam position.
- `mode`, in, 2: pattern select (shadowed, see Operation).
- `speed`, in, `SPEED_W`: scroll step per frame. 0 means static.
- `dir`, in, 2: `dir[0]` selects the x direction, `dir[1]` selects the y direction. 0 means add, 1 means subtract.
- `pause`, in, 1: freezes the scroll offsets.
- `hsync_out`, `vsync_out`, out, 1 each: syncs delayed to align with the RGB outputs.
- `r`, `g`, `b`, out, `COLOR_BITS` each: pixel colour.
- `frame_tick`, out, 1: one-cycle pulse at each frame boundary.
- `scroll_x`, `scroll_y`, out, `COORD_W` each: current offsets (status).

## Operation
Frame edge detection:
- `vs_prev` register, reset value 1.
- Edge condition: `vsync_in && !vs_prev`, i.e. the end of the sync pulse.
- On the clock edge that samples the edge condition, `frame_tick` is registered high for exactly one cycle.

Shadow registers:
- `mode`, `speed` and `dir` are copied into active registers only on the edge condition. This happens even when `pause` is high.
- Reset values of the active registers: mode 0, speed 0, dir 0.

Scroll offsets:
- On the edge condition with `pause` low:
  - `scroll_x <= scroll_x ± active_speed`.
  - Arithmetic is modulo 2^`COORD_W` and wraps silently.
- The step uses the previously latched `active_speed`/`active_dir`, not the values latched on the same edge.

Per-pixel computation:
- `mx = hpos + scroll_x` and `my = vpos + scroll_y`, both modulo 2^`COORD_W`.
- Let `C = COLOR_BITS`, and let `rep(v)` replicate bit `v` C times.
- Mode 0, colour bars: `r = rep(mx[COORD_W-3])`, `g = rep(mx[COORD_W-2])`, `b = rep(mx[COORD_W-1])`.
- Mode 1, checker: all channels `rep(mx[5] ^ my[5])`.
- Mode 2, gradient: `r = mx[COORD_W-1 -: C]`, `g = my[COORD_W-1 -: C]`, `b = (mx^my)[COORD_W-1 -: C]`.
- Mode 3, XOR texture, with `t = mx ^ my`: `r = t[C+1:2]`, `g = t[C+3:4]`, `b = t[C+5:6]`.
- When `display_on` is low, RGB is forced to 0.

Reset values:
- `r`, `g`, `b` = 0.
- `hsync_out`, `vsync_out` = 1.
- `frame_tick` = 0.
- `scroll_x`, `scroll_y` = 0.

## Timing
- RGB, `hsync_out` and `vsync_out` are all registered, with exactly 1 cycle latency from `hpos`/`vpos`/`display_on`/syncs. Syncs and colour stay aligned.
- `frame_tick` is high in the cycle after the edge condition. `scroll_x`/`scroll_y` and the active registers show their new values in that same cycle.
- The first pixel to use new offsets or a new mode is the one sampled in the cycle after the edge.
- Reset asserted mid-frame clears everything immediately. No `frame_tick` occurs until a low→high `vsync_in` transition is observed after reset release.
- A `pause` change takes effect at the next frame edge only.

## Configuration
- `VGA_SCROLL_Y_EN` defined:
  - `scroll_y` steps by `active_speed` in direction `active_dir[1]` on each unpaused edge.
- `VGA_SCROLL_Y_EN` undefined:
  - `scroll_y` is tied to 0.
  - `dir[1]` is latched but ignored.
  - The y-offset adder and register are absent.

## Structure
- Package `vga_pattern_pkg`:
  - Mode constants `MODE_BARS=0`, `MODE_CHECKER=1`, `MODE_GRADIENT=2`, `MODE_XOR=3`.
  - Sync idle level constant `SYNC_IDLE=1`.
- Sub-module `scroll_offset` (params `COORD_W`, `SPEED_W`):
  - Offset register with step, direction and enable inputs.
  - Instantiated for x, and for y under the macro.

## Test plan
- Reset check: assert `reset` mid-line. All outputs take their reset values asynchronously, before the next clock edge.
- X scroll: speed=3, dir=0, two frame edges → `scroll_x`=6 with two `frame_tick` pulses. Mode 0 pixel at hpos=0 then matches `mx`=6.
- Wrap: speed=1, dir[0]=1 from 0, one edge → `scroll_x`=1023 (COORD_W=10).
- Shadowing: change `mode` 0→1 mid-frame. Output stays bars until the cycle after the next edge, then becomes checker.
- Blanking and latency: `display_on`=0 → RGB=0 one cycle later. The `hsync_out` edge lags `hsync_in` by exactly 1 cycle.
- Pause and Y scroll: with `pause`=1, offsets stay constant across 3 edges. With the macro defined, speed=2, dir=0b10 → `scroll_y` = 1022 after one unpaused edge. Without the macro, `scroll_y` = 0.

Source files
------------

// File: rtl/vga_pattern_pkg.sv
// Shared constants for the scrolling VGA test-pattern generator.
package vga_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_CHECKER  = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_XOR      = 2'd3
  } mode_e;

  localparam logic SYNC_IDLE = 1'b1;

endpackage

// File: rtl/scroll_offset.sv
// One scroll-offset register: steps by +/- step when enabled, wraps modulo 2^COORD_W.
module scroll_offset #(
  parameter int COORD_W = 10,
  parameter int SPEED_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               dir,
  input  logic [SPEED_W-1:0] step,
  output logic [COORD_W-1:0] offset
);

  logic [COORD_W-1:0] offset_q, offset_d, step_ext;

  always_comb begin
    step_ext = COORD_W'(step);
    offset_d = offset_q;
    if (en) offset_d = dir ? (offset_q - step_ext) : (offset_q + step_ext);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) offset_q <= '0;
    else       offset_q <= offset_d;
  end

  assign offset = offset_q;

endmodule

// File: rtl/vga_pattern_scroller.sv
// Scrolling VGA test pattern, four modes, registered/blanked RGB with aligned syncs.
// Vertical scroll is built only when VGA_SCROLL_Y_EN is defined.
module vga_pattern_scroller
  import vga_pattern_pkg::*;
#(
  parameter int COORD_W    = 10,
  parameter int COLOR_BITS = 2,
  parameter int SPEED_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  display_on,
  input  logic [COORD_W-1:0]    hpos,
  input  logic [COORD_W-1:0]    vpos,
  input  logic [1:0]            mode,
  input  logic [SPEED_W-1:0]    speed,
  input  logic [1:0]            dir,
  input  logic                  pause,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b,
  output logic                  frame_tick,
  output logic [COORD_W-1:0]    scroll_x,
  output logic [COORD_W-1:0]    scroll_y
);

  localparam int C = COLOR_BITS;

  logic               vs_prev_q, vs_prev_d;
  logic               frame_tick_q, frame_tick_d;
  mode_e              active_mode_q, active_mode_d;
  logic [SPEED_W-1:0] active_speed_q, active_speed_d;
  logic [1:0]         active_dir_q, active_dir_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d;
  logic [C-1:0]       r_q, r_d, g_q, g_d, b_q, b_d;

  logic               frame_edge, step_en;
  logic [COORD_W-1:0] mx, my, t;

  // End of the vsync pulse marks the frame boundary.
  assign frame_edge = vsync_in && !vs_prev_q;
  assign step_en    = frame_edge && !pause;

  // Steps use the previously latched speed/dir, so the new shadow values apply next frame.
  scroll_offset #(.COORD_W(COORD_W), .SPEED_W(SPEED_W)) u_scroll_x (
    .clk    (clk),
    .reset  (reset),
    .en     (step_en),
    .dir    (active_dir_q[0]),
    .step   (active_speed_q),
    .offset (scroll_x)
  );

`ifdef VGA_SCROLL_Y_EN
  scroll_offset #(.COORD_W(COORD_W), .SPEED_W(SPEED_W)) u_scroll_y (
    .clk    (clk),
    .reset  (reset),
    .en     (step_en),
    .dir    (active_dir_q[1]),
    .step   (active_speed_q),
    .offset (scroll_y)
  );
`else
  logic unused_dir_y;
  assign unused_dir_y = active_dir_q[1];
  assign scroll_y     = '0;
`endif

  always_comb begin
    vs_prev_d      = vsync_in;
    frame_tick_d   = frame_edge;
    active_mode_d  = active_mode_q;
    active_speed_d = active_speed_q;
    active_dir_d   = active_dir_q;
    if (frame_edge) begin
      active_mode_d  = mode_e'(mode);
      active_speed_d = speed;
      active_dir_d   = dir;
    end
    hsync_d = hsync_in;
    vsync_d = vsync_in;
  end

  always_comb begin
    mx  = hpos + scroll_x;
    my  = vpos + scroll_y;
    t   = mx ^ my;
    r_d = '0;
    g_d = '0;
    b_d = '0;
    case (active_mode_q)
      MODE_BARS: begin
        r_d = {C{mx[COORD_W-3]}};
        g_d = {C{mx[COORD_W-2]}};
        b_d = {C{mx[COORD_W-1]}};
      end
      MODE_CHECKER: begin
        r_d = {C{mx[5] ^ my[5]}};
        g_d = {C{mx[5] ^ my[5]}};
        b_d = {C{mx[5] ^ my[5]}};
      end
      MODE_GRADIENT: begin
        r_d = mx[COORD_W-1 -: C];
        g_d = my[COORD_W-1 -: C];
        b_d = t[COORD_W-1 -: C];
      end
      MODE_XOR: begin
        r_d = t[C+1:2];
        g_d = t[C+3:4];
        b_d = t[C+5:6];
      end
      default: ;
    endcase
    if (!display_on) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  logic [1:0] unused_t_lsb;
  assign unused_t_lsb = t[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_prev_q      <= 1'b1;
      frame_tick_q   <= 1'b0;
      active_mode_q  <= MODE_BARS;
      active_speed_q <= '0;
      active_dir_q   <= '0;
      hsync_q        <= SYNC_IDLE;
      vsync_q        <= SYNC_IDLE;
      r_q            <= '0;
      g_q            <= '0;
      b_q            <= '0;
    end else begin
      vs_prev_q      <= vs_prev_d;
      frame_tick_q   <= frame_tick_d;
      active_mode_q  <= active_mode_d;
      active_speed_q <= active_speed_d;
      active_dir_q   <= active_dir_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      r_q            <= r_d;
      g_q            <= g_d;
      b_q            <= b_d;
    end
  end

  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign r          = r_q;
  assign g          = g_q;
  assign b          = b_q;
  assign frame_tick = frame_tick_q;

endmodule
